// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the RV32I integer
// computational subset (OP, OP-IMM, LUI, AUIPC). Decodes the instruction,
// resolves forwarded source operands and registers the ALU operands, the ALU
// operation code and the writeback tag for the execute stage.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_valid, o_id_ready upstream handshake (o_id_ready is combinational)
//   i_instr, i_pc       instruction word and address
//   i_rs1_data/rs2_data register-file reads of instr[19:15] / instr[24:20]
//   i_fwd_ex_*          EX-stage forwarding path (we, rd, data)
//   i_fwd_mem_*         MEM-stage forwarding path (we, rd, data)
//   i_flush             kill held and incoming instruction
//   i_ex_ready          execute stage accepts this cycle
//   o_valid .. o_illegal registered payload for the execute stage
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_id_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_fwd_ex_we,
    input  logic [4:0]      i_fwd_ex_rd,
    input  logic [XLEN-1:0] i_fwd_ex_data,
    input  logic            i_fwd_mem_we,
    input  logic [4:0]      i_fwd_mem_rd,
    input  logic [XLEN-1:0] i_fwd_mem_data,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_op_a,
    output logic [XLEN-1:0] o_op_b,
    output logic [3:0]      o_alu_op,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic [XLEN-1:0] o_pc,
    output logic            o_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    alu_op_e         dec_alu;
    logic            dec_illegal;
    logic            accept;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign rd     = i_instr[11:7];
    assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_u  = {i_instr[31:12], 12'b0};
    assign shamt  = {27'b0, i_instr[24:20]};

    assign o_id_ready = !o_valid || i_ex_ready;
    assign accept     = i_valid && o_id_ready && !i_flush;

    // x0 always reads zero; EX beats MEM beats the register file. A match
    // requires src != 0, so a forward with rd == 0 can never be selected.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data
    );
        if (src == 5'd0)                   return '0;
        else if (ex_we && ex_rd == src)    return ex_data;
        else if (mem_we && mem_rd == src)  return mem_data;
        else                               return rf;
    endfunction

    // funct3 to ALU op for the shared OP / OP-IMM table (no SUB/SRA here).
    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    assign src1 = fwd_select(rs1, i_rs1_data, i_fwd_ex_we, i_fwd_ex_rd, i_fwd_ex_data,
                             i_fwd_mem_we, i_fwd_mem_rd, i_fwd_mem_data);
    assign src2 = fwd_select(rs2, i_rs2_data, i_fwd_ex_we, i_fwd_ex_rd, i_fwd_ex_data,
                             i_fwd_mem_we, i_fwd_mem_rd, i_fwd_mem_data);

    // Instruction decode. Illegal encodings collapse to ADD with zero
    // operands so the execute stage sees a harmless, deterministic payload.
    always_comb begin
        dec_illegal = 1'b0;
        dec_alu     = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        case (opcode)
            OPC_OP: begin
                dec_a = src1;
                dec_b = src2;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'h00)      dec_alu = ALU_ADD;
                        else if (funct7 == 7'h20) dec_alu = ALU_SUB;
                        else                      dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'h00)      dec_alu = ALU_SRL;
                        else if (funct7 == 7'h20) dec_alu = ALU_SRA;
                        else                      dec_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'h00)      dec_alu = base_op(funct3);
                        else                      dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OPIMM: begin
                dec_a = src1;
                dec_b = imm_i;
                case (funct3)
                    3'b001: begin
                        dec_b   = shamt;
                        dec_alu = ALU_SLL;
                        if (funct7 != 7'h00) dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        dec_b = shamt;
                        if (funct7 == 7'h00)      dec_alu = ALU_SRL;
                        else if (funct7 == 7'h20) dec_alu = ALU_SRA;
                        else                      dec_illegal = 1'b1;
                    end
                    default: dec_alu = base_op(funct3);
                endcase
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = i_pc;
                dec_b = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_alu = ALU_ADD;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    // Pipeline register. Flush only clears valid; a stall (not ready) leaves
    // every payload bit untouched, so forwarded values are captured once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_op_a    <= '0;
            o_op_b    <= '0;
            o_alu_op  <= '0;
            o_rd      <= '0;
            o_rd_we   <= 1'b0;
            o_pc      <= '0;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (o_id_ready) begin
            o_valid <= i_valid;
            if (accept) begin
                o_op_a    <= dec_a;
                o_op_b    <= dec_b;
                o_alu_op  <= dec_alu;
                o_rd      <= rd;
                o_rd_we   <= !dec_illegal && (rd != 5'd0);
                o_pc      <= i_pc;
                o_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RV32I core; sits directly upstream of the ALU.
- Decodes the integer-computational subset: OP, OP-IMM, LUI and AUIPC.
- Selects forwarded operands and registers op_a, op_b, alu_op and the writeback tag for the execute stage.
- Single-entry pipeline register with a valid/ready handshake, stall and flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  upstream instruction valid.
o_id_ready  out  1  stage can accept; combinational.
i_instr  in  32  instruction word.
i_pc  in  32  instruction address.
i_rs1_data  in  32  register-file read of instr[19:15].
i_rs2_data  in  32  register-file read of instr[24:20].
i_fwd_ex_we  in  1  EX-stage result will be written.
i_fwd_ex_rd  in  5  EX-stage destination.
i_fwd_ex_data  in  32  EX-stage result.
i_fwd_mem_we  in  1  MEM-stage result will be written.
i_fwd_mem_rd  in  5  MEM-stage destination.
i_fwd_mem_data  in  32  MEM-stage result.
i_flush  in  1  kill the held and incoming instruction.
i_ex_ready  in  1  execute stage accepts this cycle.
o_valid  out  1  registered payload valid.
o_op_a  out  32  ALU operand A.
o_op_b  out  32  ALU operand B.
o_alu_op  out  4  ALU operation code.
o_rd  out  5  destination register.
o_rd_we  out  1  writeback enable.
o_pc  out  32  registered PC.
o_illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset values: all registered outputs are 0; o_valid=0.
- Handshake:
  - o_id_ready = !o_valid | i_ex_ready.
  - On accept (i_valid & o_id_ready & !i_flush), the payload is registered and o_valid=1 on the next cycle.
  - Latency is 1 cycle.
- Stall: o_valid & !i_ex_ready holds every output bit-stable and no new instruction is accepted.
- Bubble: o_id_ready & !i_valid sets o_valid to 0. Payload registers may hold their old values.
- Flush:
  - i_flush sets o_valid to 0 next cycle, regardless of i_ex_ready.
  - The incoming instruction in the same cycle is discarded.
  - Priority order: i_rst > i_flush > accept.
- alu_op codes: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9.
- OP (opcode 0110011): op_a=rs1, op_b=rs2.
  - funct3 000 gives ADD (funct7=0x00) or SUB (0x20).
  - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - funct3 101 gives SRL (0x00) or SRA (0x20).
  - Any other funct7 is illegal.
- OP-IMM (0010011): op_a=rs1, op_b=sign-extended instr[31:20]. funct3 map is as for OP, with these differences:
  - 000 is always ADD.
  - Shifts use op_b = {27'b0, instr[24:20]}.
  - SLLI requires funct7=0x00. SRLI/SRAI require funct7 0x00/0x20.
- LUI (0110111): op_a=0, op_b={instr[31:12],12'b0}, ADD.
- AUIPC (0010111): op_a=i_pc, op_b={instr[31:12],12'b0}, ADD.
- Illegal cases (any other opcode or bad funct7): o_illegal=1, o_rd_we=0, o_alu_op=ADD, o_op_a=o_op_b=0, o_valid still asserted.
- Writeback: o_rd=instr[11:7]. o_rd_we=1 for legal instructions with rd!=0, else 0.
- Forwarding, evaluated per source, only where that source register is used:
  - Source index 0 yields 0.
  - Otherwise EX match (we & rd==src) wins.
  - Then MEM match.
  - Then register-file data.
  - Forward enables with rd==0 never match.
- Forward sampling: forwarding inputs are sampled only in the accept cycle. A stalled payload is not re-forwarded.
- Arithmetic: all immediates are formed to 32 bits before registering. No arithmetic is performed in this stage.

Test Plan:
- Reset mid-stall: o_valid=1 with i_ex_ready=0, then assert i_rst for 1 cycle -> next cycle o_valid=0 and all outputs 0.
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=10, no forwarding -> after 1 cycle: o_op_a=10, o_op_b=0xFFFFFFFF, o_alu_op=0, o_rd=5, o_rd_we=1.
- SRA x3,x1,x2 (0x4020D1B3) with EX fwd rd=1 data=0x80000000 and MEM fwd rd=1 data=7 -> o_op_a=0x80000000 (EX priority), o_alu_op=9. Repeat with rs1=x0 -> o_op_a=0.
- AUIPC x4,0x12345 at pc=0x100 -> o_op_a=0x100, o_op_b=0x12345000, o_alu_op=0.
- Stall/flush:
  - Accept ADD, hold i_ex_ready=0 for 3 cycles while changing inputs -> outputs stable and o_id_ready=0.
  - Then i_flush=1 -> o_valid=0 next cycle.
- Illegal encodings: opcode 0x03, and ADD with funct7=0x01 -> o_illegal=1, o_rd_we=0, o_valid=1.
